lms_sample_aligner: RTL and testbench

Upstream front-end for `LMS_filter`. It accepts the reference-input stream `u` and the desired-signal stream `d`, each with its own single-cycle valid strobe at audio sample rate. The block buffers each stream in a small FIFO and pairs the samples. It then presents each pair to the filter as one-cycle `valid_u_in`/`valid_d_in` pulses, no closer together than the filter's per-sample processing time. If one stream stalls, the block emits a partial pair after a timeout, so the filter keeps running on the stream that is still present.

---
 rtl/lms_pkg.sv | 26 ++
 rtl/sample_fifo.sv | 83 ++++++++
 rtl/lms_sample_aligner.sv | 180 ++++++++++++++++++
 tb/tb_lms_sample_aligner.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lms_pkg.sv
// lms_pkg: shared definitions for the LMS sample aligner.
//   state_e   - pairing FSM states (IDLE/WAIT/EMIT/HOLD)
//   DEFAULT_W - default sample width
//   clog2()   - ceiling log2, used to size the timer, gap counter and FIFO pointers
package lms_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_EMIT = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    localparam int DEFAULT_W = 16;

    // Number of bits needed to hold values 0 .. value-1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: single-channel first-word-fall-through sample buffer.
//   clk, rst - rising-edge clock, synchronous active-high reset
//   push/din - write din on this edge (dropped if full and not popped)
//   pop      - remove the head on this edge (ignored when empty)
//   dout     - current head sample
//   empty    - no samples stored
//   full     - DEPTH samples stored
//   ovf      - sticky: a sample was dropped; cleared only by rst
module sample_fifo
    import lms_pkg::*;
#(
    parameter int W     = DEFAULT_W,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full,
    output logic         ovf
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             wr_en, rd_en;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign dout  = mem_q[rd_ptr_q];
    assign ovf   = ovf_q;

    always_comb begin
        rd_en    = pop && !empty;
        // A full FIFO still accepts a push when the head leaves on the same edge.
        wr_en    = push && (!full || rd_en);
        ovf_d    = ovf_q || (push && full && !rd_en);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (wr_en && !rd_en) begin
            count_d = count_q + CNT_W'(1);
        end else if (rd_en && !wr_en) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Sample storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/lms_sample_aligner.sv
// lms_sample_aligner: pairs the reference (u) and desired (d) sample streams
// for an LMS filter, spacing emitted pairs at least GAP clocks apart and
// emitting a partial pair when one stream stalls for TIMEOUT clocks.
//   clk, rst              - rising-edge clock, synchronous active-high reset
//   u_in/u_valid          - reference sample and one-cycle push strobe
//   d_in/d_valid          - desired sample and one-cycle push strobe
//   u_out/d_out           - registered samples presented to the filter
//   valid_u_out/valid_d_out - one-cycle strobes, high only in the EMIT cycle
//   ovf_u/ovf_d           - sticky per-channel FIFO overflow flags
//   miss_cnt              - saturating count of partial emits
module lms_sample_aligner
    import lms_pkg::*;
#(
    parameter int W       = DEFAULT_W,
    parameter int DEPTH   = 4,
    parameter int GAP     = 17,
    parameter int TIMEOUT = 4096
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] u_in,
    input  logic         u_valid,
    input  logic [W-1:0] d_in,
    input  logic         d_valid,
    output logic [W-1:0] u_out,
    output logic [W-1:0] d_out,
    output logic         valid_u_out,
    output logic         valid_d_out,
    output logic         ovf_u,
    output logic         ovf_d,
    output logic [15:0]  miss_cnt
);

    localparam int TIMER_W = clog2(TIMEOUT);
    localparam int GAP_W   = clog2(GAP);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP - 2);

    logic [W-1:0] u_head, d_head;
    logic         u_empty, d_empty, u_full, d_full;
    logic         u_ne, d_ne;
    logic         pop_u, pop_d;
    logic         unused_full;

    state_e             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [W-1:0]       u_out_q, u_out_d;
    logic [W-1:0]       d_out_q, d_out_d;
    logic               valid_u_q, valid_u_d;
    logic               valid_d_q, valid_d_d;
    logic [15:0]        miss_q, miss_d;
    logic               decide, emit_go, partial;

    sample_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (u_valid),
        .din   (u_in),
        .pop   (pop_u),
        .dout  (u_head),
        .empty (u_empty),
        .full  (u_full),
        .ovf   (ovf_u)
    );

    sample_fifo #(.W(W), .DEPTH(DEPTH)) d_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (d_valid),
        .din   (d_in),
        .pop   (pop_d),
        .dout  (d_head),
        .empty (d_empty),
        .full  (d_full),
        .ovf   (ovf_d)
    );

    assign unused_full = u_full ^ d_full;
    assign u_ne        = !u_empty;
    assign d_ne        = !d_empty;
    assign pop_u       = emit_go && u_ne;
    assign pop_d       = emit_go && d_ne;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        gap_d     = gap_q;
        u_out_d   = u_out_q;
        d_out_d   = d_out_q;
        valid_u_d = 1'b0;
        valid_d_d = 1'b0;
        miss_d    = miss_q;
        decide    = 1'b0;
        emit_go   = 1'b0;
        partial   = 1'b0;

        unique case (state_q)
            ST_IDLE: decide = 1'b1;
            ST_WAIT: begin
                if (u_ne && d_ne) begin
                    emit_go = 1'b1;
                end else if (timer_q == TIMER_LAST) begin
                    emit_go = 1'b1;
                    partial = 1'b1;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            ST_EMIT: begin
                state_d = ST_HOLD;
                gap_d   = '0;
            end
            ST_HOLD: begin
                // The last HOLD cycle makes the IDLE decision itself, so a
                // backlogged pair is emitted exactly GAP clocks after the last.
                if (gap_q == GAP_LAST) begin
                    decide = 1'b1;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
        endcase

        if (decide) begin
            if (u_ne && d_ne) begin
                emit_go = 1'b1;
            end else if (u_ne || d_ne) begin
                state_d = ST_WAIT;
                timer_d = '0;
            end else begin
                state_d = ST_IDLE;
            end
        end

        if (emit_go) begin
            state_d = ST_EMIT;
            if (u_ne) begin
                u_out_d   = u_head;
                valid_u_d = 1'b1;
            end
            if (d_ne) begin
                d_out_d   = d_head;
                valid_d_d = 1'b1;
            end
            if (partial && (miss_q != 16'hFFFF)) begin
                miss_d = miss_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            gap_q     <= '0;
            u_out_q   <= '0;
            d_out_q   <= '0;
            valid_u_q <= 1'b0;
            valid_d_q <= 1'b0;
            miss_q    <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            gap_q     <= gap_d;
            u_out_q   <= u_out_d;
            d_out_q   <= d_out_d;
            valid_u_q <= valid_u_d;
            valid_d_q <= valid_d_d;
            miss_q    <= miss_d;
        end
    end

    assign u_out       = u_out_q;
    assign d_out       = d_out_q;
    assign valid_u_out = valid_u_q;
    assign valid_d_out = valid_d_q;
    assign miss_cnt    = miss_q;

endmodule

// File: tb/tb_lms_sample_aligner.sv
// tb_lms_sample_aligner: directed bench for lms_sample_aligner with a
// time-based reference model (sample queues, earliest-next-emit edge and a
// lone-sample deadline) compared against the DUT every cycle, plus
// hand-computed literal expectations for each scenario.
module tb_lms_sample_aligner;

    localparam int W       = 16;
    localparam int DEPTH   = 4;
    localparam int GAP     = 17;
    localparam int TIMEOUT = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] u_in, d_in;
    logic         u_valid, d_valid;
    logic [W-1:0] u_out, d_out;
    logic         valid_u_out, valid_d_out;
    logic         ovf_u, ovf_d;
    logic [15:0]  miss_cnt;

    lms_sample_aligner #(.W(W), .DEPTH(DEPTH), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .u_in        (u_in),
        .u_valid     (u_valid),
        .d_in        (d_in),
        .d_valid     (d_valid),
        .u_out       (u_out),
        .d_out       (d_out),
        .valid_u_out (valid_u_out),
        .valid_d_out (valid_d_out),
        .ovf_u       (ovf_u),
        .ovf_d       (ovf_d),
        .miss_cnt    (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int           cyc = 0;
    bit           live = 1'b0;
    logic [W-1:0] uq[$], dq[$];
    bit           waiting;
    int           wait_start, next_ok;
    bit           m_un, m_dn, m_emit;
    logic [W-1:0] exp_u_out, exp_d_out;
    bit           exp_vu, exp_vd, exp_ovf_u, exp_ovf_d;
    logic [15:0]  exp_miss;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            uq.delete();
            dq.delete();
            waiting   = 1'b0;
            next_ok   = 0;
            exp_u_out = '0;
            exp_d_out = '0;
            exp_vu    = 1'b0;
            exp_vd    = 1'b0;
            exp_ovf_u = 1'b0;
            exp_ovf_d = 1'b0;
            exp_miss  = '0;
            live      = 1'b1;
        end else begin
            m_un   = uq.size() > 0;
            m_dn   = dq.size() > 0;
            m_emit = 1'b0;
            if (cyc >= next_ok) begin
                if (m_un && m_dn) begin
                    m_emit = 1'b1;
                end else if (waiting && cyc == wait_start + TIMEOUT) begin
                    m_emit = 1'b1;
                end else if (!waiting && (m_un || m_dn)) begin
                    waiting    = 1'b1;
                    wait_start = cyc;
                end
            end
            exp_vu = 1'b0;
            exp_vd = 1'b0;
            if (m_emit) begin
                if (m_un) begin
                    exp_u_out = uq.pop_front();
                    exp_vu    = 1'b1;
                end
                if (m_dn) begin
                    exp_d_out = dq.pop_front();
                    exp_vd    = 1'b1;
                end
                if ((m_un != m_dn) && exp_miss != 16'hFFFF) exp_miss = exp_miss + 16'd1;
                waiting = 1'b0;
                next_ok = cyc + GAP;
            end
            if (u_valid) begin
                if (uq.size() < DEPTH) uq.push_back(u_in);
                else exp_ovf_u = 1'b1;
            end
            if (d_valid) begin
                if (dq.size() < DEPTH) dq.push_back(d_in);
                else exp_ovf_d = 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare + emit log ----------------
    int           emit_cyc[$];
    logic [W-1:0] emit_u[$], emit_d[$];
    bit           emit_vu[$], emit_vd[$];

    always @(negedge clk) begin
        if (live) begin
            chk($sformatf("u_out@%0d", cyc), int'(u_out), int'(exp_u_out));
            chk($sformatf("d_out@%0d", cyc), int'(d_out), int'(exp_d_out));
            chk($sformatf("valid_u_out@%0d", cyc), int'(valid_u_out), int'(exp_vu));
            chk($sformatf("valid_d_out@%0d", cyc), int'(valid_d_out), int'(exp_vd));
            chk($sformatf("ovf_u@%0d", cyc), int'(ovf_u), int'(exp_ovf_u));
            chk($sformatf("ovf_d@%0d", cyc), int'(ovf_d), int'(exp_ovf_d));
            chk($sformatf("miss_cnt@%0d", cyc), int'(miss_cnt), int'(exp_miss));
            if (valid_u_out || valid_d_out) begin
                emit_cyc.push_back(cyc);
                emit_u.push_back(u_out);
                emit_d.push_back(d_out);
                emit_vu.push_back(valid_u_out);
                emit_vd.push_back(valid_d_out);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input bit uv, input logic [W-1:0] uval,
                        input bit dv, input logic [W-1:0] dval);
        u_valid = uv;
        u_in    = uval;
        d_valid = dv;
        d_in    = dval;
        @(posedge clk);
        #2;
        u_valid = 1'b0;
        d_valid = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_log();
        emit_cyc.delete();
        emit_u.delete();
        emit_d.delete();
        emit_vu.delete();
        emit_vd.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    int e;

    initial begin
        rst     = 1'b1;
        u_valid = 1'b0;
        d_valid = 1'b0;
        u_in    = '0;
        d_in    = '0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("reset_u_out", int'(u_out), 0);
        chk("reset_valid", int'({valid_u_out, valid_d_out}), 0);
        chk("reset_ovf", int'({ovf_u, ovf_d}), 0);
        chk("reset_miss", int'(miss_cnt), 0);

        // Simultaneous pair: strobes only in the cycle after push edge + 1
        clear_log();
        push(1'b1, 16'h0801, 1'b1, 16'hC000);
        @(negedge clk);
        chk("pair_early_valid", int'({valid_u_out, valid_d_out}), 0);
        @(negedge clk);
        chk("pair_valid", int'({valid_u_out, valid_d_out}), 3);
        chk("pair_u_out", int'(u_out), 16'h0801);
        chk("pair_d_out", int'(d_out), 16'hC000);
        @(negedge clk);
        chk("pair_late_valid", int'({valid_u_out, valid_d_out}), 0);
        wait_cyc(20);

        // Back-to-back: four pairs, emits exactly GAP apart in push order
        clear_log();
        push(1'b1, 16'h1001, 1'b1, 16'h8001);
        e = cyc;
        for (int i = 1; i < 4; i++) push(1'b1, 16'(16'h1001 + i), 1'b1, 16'(16'h8001 + i));
        wait_cyc(80);
        chk("b2b_count", emit_cyc.size(), 4);
        if (emit_cyc.size() == 4) begin
            chk("b2b_first_latency", emit_cyc[0] - e, 1);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("b2b_u%0d", i), int'(emit_u[i]), 16'h1001 + i);
                chk($sformatf("b2b_d%0d", i), int'(emit_d[i]), 16'h8001 + i);
                if (i > 0) chk($sformatf("b2b_gap%0d", i), emit_cyc[i] - emit_cyc[i-1], GAP);
            end
        end
        chk("b2b_ovf", int'({ovf_u, ovf_d}), 0);

        // u only: partial emit after TIMEOUT, d_out held
        clear_log();
        push(1'b1, 16'h0005, 1'b0, 16'h0000);
        e = cyc;
        wait_cyc(30);
        chk("uonly_count", emit_cyc.size(), 1);
        if (emit_cyc.size() == 1) begin
            chk("uonly_time", emit_cyc[0] - e, TIMEOUT + 1);
            chk("uonly_u", int'(emit_u[0]), 16'h0005);
            chk("uonly_vu_vd", int'({emit_vu[0], emit_vd[0]}), 2);
            chk("uonly_d_held", int'(emit_d[0]), 16'h8004);
        end
        chk("uonly_miss", int'(miss_cnt), 1);

        // Overflow: five u pushes, fifth dropped; then d catches up
        clear_log();
        for (int i = 0; i < 5; i++) push(1'b1, 16'(16'h2001 + i), 1'b0, 16'h0000);
        chk("ovf_u_set", int'(ovf_u), 1);
        for (int i = 0; i < 4; i++) push(1'b0, 16'h0000, 1'b1, 16'(16'h3001 + i));
        wait_cyc(80);
        chk("ovf_count", emit_cyc.size(), 4);
        if (emit_cyc.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("ovf_u%0d", i), int'(emit_u[i]), 16'h2001 + i);
                chk($sformatf("ovf_d%0d", i), int'(emit_d[i]), 16'h3001 + i);
            end
        end
        chk("ovf_flags", int'({ovf_u, ovf_d}), 2);
        chk("ovf_miss", int'(miss_cnt), 1);

        // Partner on the exact timeout edge: full pair wins
        clear_log();
        push(1'b1, 16'h0055, 1'b0, 16'h0000);
        e = cyc;
        wait_cyc(TIMEOUT - 1);
        push(1'b0, 16'h0000, 1'b1, 16'h00AA);
        wait_cyc(30);
        chk("edge_count", emit_cyc.size(), 1);
        if (emit_cyc.size() == 1) begin
            chk("edge_time", emit_cyc[0] - e, TIMEOUT + 1);
            chk("edge_vu_vd", int'({emit_vu[0], emit_vd[0]}), 3);
            chk("edge_d", int'(emit_d[0]), 16'h00AA);
        end
        chk("edge_miss", int'(miss_cnt), 1);

        // Reset during HOLD with three samples buffered
        push(1'b1, 16'h4001, 1'b1, 16'h5001);
        push(1'b1, 16'h4002, 1'b1, 16'h5002);
        push(1'b1, 16'h4003, 1'b0, 16'h0000);
        wait_cyc(2);
        chk("prerst_ovf_u", int'(ovf_u), 1);
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        clear_log();
        @(negedge clk);
        chk("rst_outs", int'({valid_u_out, valid_d_out, ovf_u, ovf_d}), 0);
        chk("rst_u_out", int'(u_out), 0);
        chk("rst_d_out", int'(d_out), 0);
        chk("rst_miss", int'(miss_cnt), 0);
        wait_cyc(30);
        chk("rst_no_emit", emit_cyc.size(), 0);
        push(1'b1, 16'h6001, 1'b1, 16'h7001);
        wait_cyc(5);
        chk("rst_new_pair", emit_cyc.size(), 1);
        if (emit_cyc.size() == 1) chk("rst_new_u", int'(emit_u[0]), 16'h6001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
